clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Parametrised multi-channel clock-enable/divider bank, clocked from the 50 MHz board clock. It generates NUM_CH independent square waves, each with a period that can be reprogrammed at runtime. Period changes are glitch-free: a new value takes effect only at a period boundary. The block feeds display scan, debounce and timebase logic that previously needed a fixed-ratio divider per frequency.

## Interface
- NUM_CH, 2, number of divider channels (1..16)
- CNT_W, 28, counter and period width in bits
- DIV_DEFAULT, 50000000, period in input clocks loaded into every channel at reset
- clk_50m  in  1  system clock, all logic on its rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- en  in  NUM_CH  per-channel enable
- sync_rst  in  1  restarts all channels phase-aligned
- div_wr  in  1  single-cycle write strobe for a period value
- div_sel  in  max(1,$clog2(NUM_CH))  target channel of div_wr
- div_val  in  CNT_W  new period in input clocks
- div_pend  out  NUM_CH  written period not yet applied
- clk_out  out  NUM_CH  divided square wave
- tick  out  NUM_CH  one-cycle pulse per period (see Configuration)

## Operation
- Per channel: active period P, shadow period S, counter cnt in 0..P-1, pend flag.
- Reset (rst_n=0 at an edge): cnt=0, P=S=clamp(DIV_DEFAULT), clk_out=0, tick=0, div_pend=0.
- Clamp: any period value <2 becomes 2. Maximum period is 2^CNT_W-1.
- Counting, while en=1: if cnt==P-1, cnt<=0 (wrap); otherwise cnt<=cnt+1.
- clk_out is registered. It equals 1 when the next cnt is >= P>>1, else 0. Each period is therefore P>>1 cycles low followed by P-(P>>1) cycles high. Low phase comes first; for odd P the high phase is longer by one cycle.
- en=0: cnt<=0 and clk_out<=0 on the next edge, and the channel stays frozen. Re-enabling starts a fresh low phase at cnt=0.
- Write: div_wr=1 with div_sel<NUM_CH sets S<=clamp(div_val) and pend<=1. If div_sel>=NUM_CH, the write is ignored.
- Apply: on a wrap, on any cycle with en=0, or on sync_rst, if pend=1 then P<=S and pend<=0. The new P governs the period that starts at cnt=0.
- Write while pend=1: S is overwritten (last write wins) and pend stays 1.
- Write in the same cycle as a wrap or apply: the write updates S and sets pend. It does not take effect at that boundary; it waits for the next one.
- sync_rst=1: every channel sets cnt<=0 and clk_out<=0, regardless of en. Pending writes are applied.
- Priority: rst_n > sync_rst > en=0 > normal count.

## Timing
- Period of clk_out: exactly P clocks, with no drift across wraps.
- Write to visible effect: div_pend rises on the edge after div_wr. The new period starts on the first wrap after that.
- A write landing in the final cycle (cnt==P-1) applies one period later, not at that wrap.
- sync_rst or en deassert: clk_out is low on the following cycle. With en=1 the first low phase is P>>1 cycles, counted from that cycle.
- Deasserting rst_n mid-operation discards all state, including pending writes.

## Configuration
- Macro CLK_DIV_BANK_TICK_EN.
- Defined: tick[ch] is registered and high for exactly one cycle when cnt becomes 0 by wrap, coincident with the first low cycle of each new period. tick does not pulse on reset, sync_rst or re-enable.
- Not defined: the tick port remains, is tied to 0, and no tick logic is generated.

## Structure
- Package clk_div_pkg holds:
  - the MIN_DIV=2 constant;
  - the default CNT_W;
  - the clamp function;
  - the channel state struct typedef (cnt, P, S, pend).
- Sub-module clk_div_ch implements one channel: counter, shadow/apply logic, clk_out and tick. The top instantiates it NUM_CH times and decodes div_wr/div_sel.
- Expected size is roughly 150-250 lines total.

## Test plan
- Reset, then en=2'b11 with NUM_CH=2 and DIV_DEFAULT=4 -> each clk_out reads 0,0,1,1 repeating. div_pend stays 0.
- Write div_val=5 to ch1 at cnt=1 -> div_pend[1]=1 on the next cycle. The current 4-cycle period completes, then ch1 runs 0,0,1,1,1 and div_pend[1] clears at the wrap. ch0 is unaffected.
- Write div_val=6 to ch0 exactly when cnt==3 (P=4) -> one more 4-cycle period, then the 6-cycle period (3 low, 3 high) starts.
- Write div_val=0, then div_val=1 -> both clamp to 2, and clk_out toggles every cycle (0,1,...). A write with div_sel=3 leaves all channels unchanged.
- Mid-high-phase, pulse sync_rst with en[1]=0 -> both channels show clk_out=0 and cnt=0 next cycle. ch0 resumes 0,0,1,1 and ch1 stays low. Deassert en[0] -> clk_out[0]=0 next cycle.
- With CLK_DIV_BANK_TICK_EN defined and P=4 -> tick pulses every 4 cycles, aligned with clk_out falling to 0. No tick after reset or sync_rst until the first wrap. Without the macro, tick stays 0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants, channel state record and period clamp for the clk_div_bank divider.
// Channel state is held at a fixed 32-bit width; narrower CNT_W builds keep the upper bits at zero.
package clk_div_pkg;

  localparam int unsigned MIN_DIV   = 2;
  localparam int unsigned DEF_CNT_W = 28;
  localparam int unsigned MAX_CNT_W = 32;

  typedef struct packed {
    logic [MAX_CNT_W-1:0] cnt;
    logic [MAX_CNT_W-1:0] period;
    logic [MAX_CNT_W-1:0] shadow;
    logic                 pend;
  } ch_state_t;

  function automatic logic [MAX_CNT_W-1:0] clamp_div(input logic [MAX_CNT_W-1:0] v);
    return (v < MAX_CNT_W'(MIN_DIV)) ? MAX_CNT_W'(MIN_DIV) : v;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, shadow/active period with boundary apply, registered clk_out.
// Optional per-period tick pulse when CLK_DIV_BANK_TICK_EN is defined.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DIV_DEFAULT = 50000000
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_rst,
  input  logic             wr,
  input  logic [CNT_W-1:0] div_val,
  output logic             div_pend,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [MAX_CNT_W-1:0] W_MASK   = MAX_CNT_W'((64'd1 << CNT_W) - 64'd1);
  localparam logic [MAX_CNT_W-1:0] INIT_DIV = clamp_div(MAX_CNT_W'(DIV_DEFAULT) & W_MASK);

  ch_state_t            r_st;
  logic                 r_clk;
  logic [MAX_CNT_W-1:0] w_cnt_inc;
  logic                 w_wrap;
  logic                 w_restart;

  assign w_cnt_inc = r_st.cnt + MAX_CNT_W'(1);
  assign w_wrap    = (w_cnt_inc == r_st.period);
  assign w_restart = sync_rst | ~en | w_wrap;

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      r_st.cnt    <= '0;
      r_st.period <= INIT_DIV;
      r_st.shadow <= INIT_DIV;
      r_st.pend   <= 1'b0;
      r_clk       <= 1'b0;
    end else begin
      if (w_restart) begin
        r_st.cnt <= '0;
        r_clk    <= 1'b0;
      end else begin
        r_st.cnt <= w_cnt_inc;
        r_clk    <= (w_cnt_inc >= (r_st.period >> 1));
      end
      if (w_restart && r_st.pend) begin
        r_st.period <= r_st.shadow;
        r_st.pend   <= 1'b0;
      end
      // A write in a boundary cycle lands in the shadow only and re-arms pend.
      if (wr) begin
        r_st.shadow <= clamp_div(MAX_CNT_W'(div_val));
        r_st.pend   <= 1'b1;
      end
    end
  end

  assign clk_out  = r_clk;
  assign div_pend = r_st.pend;

`ifdef CLK_DIV_BANK_TICK_EN
  logic r_tick;

  always_ff @(posedge clk_50m) begin
    if (!rst_n) r_tick <= 1'b0;
    else        r_tick <= en & ~sync_rst & w_wrap;
  end

  assign tick = r_tick;
`else
  assign tick = 1'b0;
`endif

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel runtime-programmable clock divider bank with glitch-free period updates.
// Optional tick outputs enabled by defining CLK_DIV_BANK_TICK_EN.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DIV_DEFAULT = 50000000,
  localparam int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_rst,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] div_pend,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] w_wr;

  // Out-of-range selects match no channel, so the write is dropped.
  always_comb begin
    w_wr = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_wr[i] = div_wr && (32'(div_sel) == i);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W      (CNT_W),
      .DIV_DEFAULT(DIV_DEFAULT)
    ) u_ch (
      .clk_50m (clk_50m),
      .rst_n   (rst_n),
      .en      (en[g]),
      .sync_rst(sync_rst),
      .wr      (w_wr[g]),
      .div_val (div_val),
      .div_pend(div_pend[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed vector table, hand sequences, randomized traffic.
// Tick expectations follow CLK_DIV_BANK_TICK_EN.
module tb_clk_div_bank;

  localparam int NCH  = 3;
  localparam int CW   = 8;
  localparam int DDEF = 4;

  logic           clk_50m = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] en;
  logic           sync_rst;
  logic           div_wr;
  logic [1:0]     div_sel;
  logic [CW-1:0]  div_val;
  logic [NCH-1:0] div_pend;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  int checks = 0;
  int errors = 0;

  // Reference state: position inside the current period, active/shadow period, pending flag.
  int m_pos[NCH];
  int m_per[NCH];
  int m_shd[NCH];
  bit m_pend[NCH];
  bit m_tick[NCH];

  always #10 clk_50m = ~clk_50m;

  clk_div_bank #(
    .NUM_CH     (NCH),
    .CNT_W      (CW),
    .DIV_DEFAULT(DDEF)
  ) dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .en      (en),
    .sync_rst(sync_rst),
    .div_wr  (div_wr),
    .div_sel (div_sel),
    .div_val (div_val),
    .div_pend(div_pend),
    .clk_out (clk_out),
    .tick    (tick)
  );

  typedef struct {
    logic           rst_n;
    logic [NCH-1:0] en;
    logic           sync_rst;
    logic           div_wr;
    logic [1:0]     div_sel;
    logic [CW-1:0]  div_val;
    logic [NCH-1:0] exp_clk;
    logic [NCH-1:0] exp_pend;
  } vec_t;

  vec_t vecs[20];

  function automatic int clampv(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic logic [NCH-1:0] m_clk();
    logic [NCH-1:0] e;
    for (int c = 0; c < NCH; c++) e[c] = (m_pos[c] >= m_per[c] / 2);
    return e;
  endfunction

  function automatic logic [NCH-1:0] m_pendv();
    logic [NCH-1:0] e;
    for (int c = 0; c < NCH; c++) e[c] = m_pend[c];
    return e;
  endfunction

  function automatic logic [NCH-1:0] m_tickv();
    logic [NCH-1:0] e;
    e = '0;
`ifdef CLK_DIV_BANK_TICK_EN
    for (int c = 0; c < NCH; c++) e[c] = m_tick[c];
`endif
    return e;
  endfunction

  task automatic model_edge();
    bit boundary;
    for (int c = 0; c < NCH; c++) begin
      if (!rst_n) begin
        m_pos[c]  = 0;
        m_per[c]  = clampv(DDEF);
        m_shd[c]  = clampv(DDEF);
        m_pend[c] = 0;
        m_tick[c] = 0;
      end else begin
        m_tick[c] = 0;
        boundary  = 0;
        if (sync_rst || !en[c]) begin
          m_pos[c] = 0;
          boundary = 1;
        end else if (m_pos[c] + 1 == m_per[c]) begin
          m_pos[c]  = 0;
          boundary  = 1;
          m_tick[c] = 1;
        end else begin
          m_pos[c]++;
        end
        if (boundary && m_pend[c]) begin
          m_per[c]  = m_shd[c];
          m_pend[c] = 0;
        end
        if (div_wr && int'(div_sel) == c) begin
          m_shd[c]  = clampv(int'(div_val));
          m_pend[c] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk_50m);
    model_edge();
    @(negedge clk_50m);
    chk({tag, " clk_out"},  clk_out,  m_clk());
    chk({tag, " div_pend"}, div_pend, m_pendv());
    chk({tag, " tick"},     tick,     m_tickv());
  endtask

  task automatic write(input int sel, input int val, input string tag);
    div_wr  = 1'b1;
    div_sel = 2'(sel);
    div_val = CW'(val);
    step(tag);
    div_wr  = 1'b0;
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  initial begin
    bit found;

    rst_n    = 1'b0;
    en       = '0;
    sync_rst = 1'b0;
    div_wr   = 1'b0;
    div_sel  = '0;
    div_val  = '0;

    // rst, en, sync, wr, sel, val, exp_clk {ch2,ch1,ch0}, exp_pend
    vecs[0]  = '{1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
    vecs[1]  = '{1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
    vecs[2]  = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
    vecs[3]  = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b111, 3'b000};
    vecs[4]  = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b111, 3'b000};
    vecs[5]  = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
    vecs[6]  = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
    vecs[7]  = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b111, 3'b000};
    vecs[8]  = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b111, 3'b000};
    vecs[9]  = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
    vecs[10] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
    vecs[11] = '{1'b1, 3'b111, 1'b0, 1'b1, 2'd1, 8'd5, 3'b111, 3'b010};
    vecs[12] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b111, 3'b010};
    vecs[13] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
    vecs[14] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
    vecs[15] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b111, 3'b000};
    vecs[16] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b111, 3'b000};
    vecs[17] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b010, 3'b000};
    vecs[18] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
    vecs[19] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b101, 3'b000};

    foreach (vecs[i]) begin
      rst_n    = vecs[i].rst_n;
      en       = vecs[i].en;
      sync_rst = vecs[i].sync_rst;
      div_wr   = vecs[i].div_wr;
      div_sel  = vecs[i].div_sel;
      div_val  = vecs[i].div_val;
      step("vec model");
      chk($sformatf("vec%0d clk_out", i),  clk_out,  vecs[i].exp_clk);
      chk($sformatf("vec%0d div_pend", i), div_pend, vecs[i].exp_pend);
    end
    div_wr = 1'b0;

    // Write landing in the final cycle of ch0's period waits one extra period.
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_pos[0] == 3 && m_per[0] == 4) found = 1;
      else step("align ch0");
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL align_ch0: got no cnt==3 window expected one within 20 cycles");
    end
    write(0, 6, "late write ch0");
    run(16, "ch0 period6");

    write(2, 0, "clamp0 ch2");
    run(5, "clamp0 run");
    write(2, 1, "clamp1 ch2");
    run(8, "clamp1 run");
    write(3, 9, "bad sel");
    run(8, "bad sel run");

    en = 3'b101;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (clk_out[0] === 1'b1 && m_clk()[0]) found = 1;
      else step("wait high ch0");
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_high: got clk_out[0]=%b expected 1 within 20 cycles", clk_out[0]);
    end
    write(1, 3, "pend ch1");
    sync_rst = 1'b1;
    step("sync_rst");
    chk("sync_rst all low", clk_out, '0);
    sync_rst = 1'b0;
    run(8, "after sync");
    en[0] = 1'b0;
    step("en0 off");
    chk("en0 off clk", {2'b00, clk_out[0]}, '0);
    run(4, "frozen");

    en = 3'b111;
    for (int k = 0; k < 500; k++) begin
      rst_n    = ($urandom % 100) != 0;
      en       = (($urandom % 8) != 0) ? 3'b111 : NCH'($urandom);
      sync_rst = ($urandom % 30) == 0;
      div_wr   = ($urandom % 5) == 0;
      div_sel  = 2'($urandom % 4);
      div_val  = CW'($urandom % 10);
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
